// File: rtl/pdm_playback_ctrl_if.sv
// Sample-stream handshake between an audio source and the PDM playback controller.
// A transfer happens in every cycle where sample_valid_in and sample_ready_out are both high.
interface pdm_playback_ctrl_if;
  logic signed [15:0] sample_in;
  logic               sample_valid_in;
  logic               sample_ready_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    output sample_ready_out
  );
endinterface

// File: rtl/pdm_playback_ctrl.sv
// Sample-rate playback controller: FIFO-buffered PCM, one sample per period,
// linear gain ramps on start/stop, hold-last-sample with underrun counting.
module pdm_playback_ctrl #(
  parameter int SAMPLE_PERIOD = 2268,
  parameter int FIFO_DEPTH    = 8,
  parameter int PREFILL       = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  pdm_playback_ctrl_if.slave  smp,
  input  logic                enable_in,
  output logic signed [15:0]  level_out,
  output logic                sample_tick_out,
  output logic                underrun_out,
  output logic [7:0]          underrun_count_out,
  output logic                playing_out
);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [TW-1:0]      tick_cnt_r;
  logic [15:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic signed [15:0] cur_sample_r, cur_sample_s;
  logic [8:0]         gain_r, gain_s;
  logic [7:0]         urun_cnt_r;
  logic               tick_s, active_s, empty_s, full_s, push_s, pop_s, underrun_s;
  logic signed [25:0] product_s;

  // Emptiness is judged before any same-cycle push, so a pop never bypasses a push.
  assign tick_s     = (tick_cnt_r == TICK_LAST);
  assign active_s   = (state_r != IDLE);
  assign empty_s    = (count_r == CW'(0));
  assign full_s     = (count_r == DEPTH_C);
  assign push_s     = smp.sample_valid_in && !full_s;
  assign pop_s      = tick_s && active_s && !empty_s;
  assign underrun_s = tick_s && active_s && empty_s;

  assign smp.sample_ready_out = !full_s;
  assign sample_tick_out      = tick_s;
  assign underrun_out         = underrun_s;
  assign underrun_count_out   = urun_cnt_r;
  assign playing_out          = active_s;

  // Free-running sample-period counter.
  always_ff @(posedge clk_in) begin
    if (rst_in || tick_s) begin
      tick_cnt_r <= TW'(0);
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Sample FIFO storage and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= smp.sample_in;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Next-state, gain and current-sample selection.
  always_comb begin
    state_s      = state_r;
    gain_s       = gain_r;
    cur_sample_s = pop_s ? mem_r[rd_ptr_r] : cur_sample_r;
    case (state_r)
      IDLE: begin
        gain_s       = 9'd0;
        cur_sample_s = 16'sd0;
        if (enable_in && (count_r >= PREFILL_C)) begin
          state_s = RAMP_UP;
        end else begin
          state_s = IDLE;
        end
      end
      RAMP_UP: begin
        if (!enable_in) begin
          state_s = RAMP_DOWN;
        end else if (gain_r >= 9'd256) begin
          state_s = PLAY;
        end else if (tick_s) begin
          gain_s  = gain_r + 9'd1;
          state_s = (gain_r == 9'd255) ? PLAY : RAMP_UP;
        end else begin
          state_s = RAMP_UP;
        end
      end
      PLAY: begin
        gain_s = 9'd256;
        if (!enable_in) begin
          state_s = RAMP_DOWN;
        end else begin
          state_s = PLAY;
        end
      end
      RAMP_DOWN: begin
        // Re-enable before the first downward step resumes full-gain play directly.
        if (enable_in) begin
          state_s = (gain_r == 9'd256) ? PLAY : RAMP_UP;
        end else if (tick_s) begin
          gain_s = gain_r - 9'd1;
          if (gain_r == 9'd1) begin
            state_s      = IDLE;
            cur_sample_s = 16'sd0;
          end else begin
            state_s = RAMP_DOWN;
          end
        end else begin
          state_s = RAMP_DOWN;
        end
      end
      default: begin
        state_s      = IDLE;
        gain_s       = 9'd0;
        cur_sample_s = 16'sd0;
      end
    endcase
  end

  // FSM, gain and held-sample registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      gain_r       <= 9'd0;
      cur_sample_r <= 16'sd0;
    end else begin
      state_r      <= state_s;
      gain_r       <= gain_s;
      cur_sample_r <= cur_sample_s;
    end
  end

  // Saturating underrun counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      urun_cnt_r <= 8'd0;
    end else if (underrun_s && (urun_cnt_r != 8'd255)) begin
      urun_cnt_r <= urun_cnt_r + 8'd1;
    end else begin
      urun_cnt_r <= urun_cnt_r;
    end
  end

  // Bits [23:8] of the signed product are the floor of product/256 and always fit 16 bits.
  assign product_s = cur_sample_r * $signed({1'b0, gain_r});

  // Registered scaled level.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      level_out <= 16'sd0;
    end else begin
      level_out <= product_s[23:8];
    end
  end
endmodule

// File: tb/tb_pdm_playback_ctrl.sv
// Scoreboard bench for pdm_playback_ctrl: a queue-based behavioural model predicts the
// outputs at every sample tick; a monitor compares them whenever the DUT pulses its tick.
module tb_pdm_playback_ctrl;
  localparam int SP    = 4;
  localparam int DEPTH = 4;
  localparam int PF    = 2;

  logic               clk       = 1'b0;
  logic               rst_in    = 1'b1;
  logic               enable_in = 1'b0;
  logic signed [15:0] level_out;
  logic               sample_tick_out;
  logic               underrun_out;
  logic [7:0]         underrun_count_out;
  logic               playing_out;
  bit                 mon_en = 1'b0;
  int                 n_checks = 0;
  int                 n_fail = 0;

  pdm_playback_ctrl_if smp();

  pdm_playback_ctrl #(.SAMPLE_PERIOD(SP), .FIFO_DEPTH(DEPTH), .PREFILL(PF)) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .smp                (smp),
    .enable_in          (enable_in),
    .level_out          (level_out),
    .sample_tick_out    (sample_tick_out),
    .underrun_out       (underrun_out),
    .underrun_count_out (underrun_count_out),
    .playing_out        (playing_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    int ur;
    int ucnt;
    int play;
    int rdy;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: 0 idle, 1 rising, 2 full volume, 3 falling.
  int m_mode = 0, m_gain = 0, m_cur = 0, m_ucnt = 0, m_tcnt = 0, m_level = 0;
  int m_q[$];

  function automatic int floor_div256(int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit tick, active, was_empty, was_full;
    int nlevel;
    if (rst_in) begin
      m_mode = 0; m_gain = 0; m_cur = 0; m_ucnt = 0; m_tcnt = 0; m_level = 0;
      m_q.delete();
    end else begin
      tick      = (m_tcnt == SP - 1);
      active    = (m_mode != 0);
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      nlevel    = floor_div256(m_cur * m_gain);
      if (tick && active) begin
        if (!was_empty) m_cur = m_q.pop_front();
        else if (m_ucnt < 255) m_ucnt++;
      end
      case (m_mode)
        0: if (enable_in && m_q.size() >= PF) m_mode = 1;
        1: begin
          if (!enable_in) m_mode = 3;
          else if (tick) begin
            m_gain++;
            if (m_gain == 256) m_mode = 2;
          end
        end
        2: if (!enable_in) m_mode = 3;
        default: begin
          if (enable_in) m_mode = (m_gain == 256) ? 2 : 1;
          else if (tick) begin
            m_gain--;
            if (m_gain == 0) begin
              m_mode = 0;
              m_cur  = 0;
            end
          end
        end
      endcase
      if (smp.sample_valid_in && !was_full) m_q.push_back(int'(smp.sample_in));
      m_level = nlevel;
      m_tcnt  = (m_tcnt + 1) % SP;
    end
    if (m_tcnt == SP - 1) begin
      sb.push_back('{level: m_level,
                     ur:    (m_mode != 0 && m_q.size() == 0) ? 1 : 0,
                     ucnt:  m_ucnt,
                     play:  (m_mode != 0) ? 1 : 0,
                     rdy:   (m_q.size() < DEPTH) ? 1 : 0});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one scoreboard entry per DUT tick pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && sample_tick_out === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick at %0t: got tick expected none", $time);
        end else begin
          mon_e = sb.pop_front();
          check("level", int'(level_out), mon_e.level);
          check("underrun", int'(underrun_out), mon_e.ur);
          check("underrun_count", int'(underrun_count_out), mon_e.ucnt);
          check("playing", int'(playing_out), mon_e.play);
          check("ready", int'(smp.sample_ready_out), mon_e.rdy);
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rate;
    smp.sample_valid_in = 1'b0;
    smp.sample_in       = 16'sd0;
    cycles(3);
    rst_in = 1'b0;
    mon_en = 1'b1;

    // Reset state and tick positions over the first 12 cycles.
    for (int c = 0; c < 12; c++) begin
      check("reset_tick", int'(sample_tick_out), (c % SP == SP - 1) ? 1 : 0);
      check("reset_level", int'(level_out), 0);
      check("reset_ready", int'(smp.sample_ready_out), 1);
      check("reset_playing", int'(playing_out), 0);
      check("reset_ucnt", int'(underrun_count_out), 0);
      cycles(1);
    end

    // Fill to full while disabled; a fifth sample must be refused.
    smp.sample_valid_in = 1'b1;
    smp.sample_in       = 16'sd1000;
    cycles(DEPTH);
    check("full_ready", int'(smp.sample_ready_out), 0);
    cycles(1);
    smp.sample_valid_in = 1'b0;
    cycles(2);
    check("full_ready_held", int'(smp.sample_ready_out), 0);
    check("full_idle", int'(playing_out), 0);
    check("full_level", int'(level_out), 0);

    // Ramp up with the FIFO topped up.
    smp.sample_valid_in = 1'b1;
    smp.sample_in       = 16'sd16384;
    enable_in           = 1'b1;
    cycles(262 * SP);
    check("play_level", int'(level_out), 16384);

    // Negative sample then ramp down to idle.
    smp.sample_in = -16'sd1000;
    cycles(20 * SP);
    check("neg_level", int'(level_out), -1000);
    enable_in = 1'b0;
    cycles(262 * SP);
    check("stopped_playing", int'(playing_out), 0);
    check("stopped_level", int'(level_out), 0);

    // Play 500 then starve the FIFO.
    smp.sample_in = 16'sd500;
    enable_in     = 1'b1;
    cycles(266 * SP);
    smp.sample_valid_in = 1'b0;
    cycles(310 * SP);
    check("starved_level", int'(level_out), 500);
    check("saturated_ucnt", int'(underrun_count_out), 255);

    // Reset partway through a ramp-up.
    enable_in = 1'b0;
    rst_in    = 1'b1;
    cycles(2);
    rst_in = 1'b0;
    smp.sample_valid_in = 1'b1;
    smp.sample_in       = 16'(int'($urandom_range(0, 32767)));
    enable_in           = 1'b1;
    cycles(100 * SP + 2);
    rst_in = 1'b1;
    cycles(1);
    check("midreset_level", int'(level_out), 0);
    check("midreset_playing", int'(playing_out), 0);
    check("midreset_ready", int'(smp.sample_ready_out), 1);
    check("midreset_ucnt", int'(underrun_count_out), 0);
    rst_in = 1'b0;
    cycles(60 * SP);

    // Randomised traffic, sample values and enable toggling.
    for (int seg = 0; seg < 6; seg++) begin
      rate = int'($urandom_range(5, 90));
      for (int c = 0; c < 500; c++) begin
        smp.sample_valid_in = ($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0;
        smp.sample_in       = 16'($urandom);
        if ($urandom_range(0, 199) == 0) enable_in = ~enable_in;
        cycles(1);
      end
    end

    cycles(1);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pdm_playback_ctrl.md
Name: pdm_playback_ctrl

Overview:
Sample-rate playback controller that sits in front of the 16-bit PDM modulator and drives its signed level input.
- Buffers incoming audio samples in a small FIFO with a valid/ready handshake.
- Releases one sample per sample period.
- Applies a click-free linear gain ramp on start and stop.
- Holds the last sample and flags underruns when the source starves the FIFO.

Parameters:
SAMPLE_PERIOD, 2268, clock cycles per output sample (100 MHz / 2268 ≈ 44.1 kHz); must be ≥ 4.
FIFO_DEPTH, 8, sample FIFO entries; power of two, ≥ 4.
PREFILL, 4, FIFO occupancy required to leave IDLE; 1..FIFO_DEPTH.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
sample_in  input  16  signed PCM sample
sample_valid_in  input  1  sample_in valid
sample_ready_out  output  1  FIFO can accept (= !full)
enable_in  input  1  level: 1 = play, 0 = stop
level_out  output  16  signed level to PDM modulator
sample_tick_out  output  1  one-cycle pulse at each sample boundary
underrun_out  output  1  one-cycle pulse: tick with empty FIFO while active
underrun_count_out  output  8  saturating underrun counter
playing_out  output  1  1 in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high on rst_in.
- Reset values: FIFO emptied, sample_ready_out=1 the cycle after reset deasserts, level_out=0, cur_sample=0, gain=0, state=IDLE, tick counter=0, sample_tick_out=0, underrun_out=0, underrun_count_out=0, playing_out=0.
- Reset mid-operation behaves identically; no ramp-down occurs.

Tick counter:
- Free-running 0..SAMPLE_PERIOD-1.
- sample_tick_out=1 in the cycle where counter==SAMPLE_PERIOD-1, i.e. every SAMPLE_PERIOD cycles; first pulse in cycle SAMPLE_PERIOD-1 after reset.

FIFO:
- Push on sample_valid_in && sample_ready_out.
- Pop only on tick in a non-IDLE state.
- Push and pop in the same cycle are both honoured.
- A pop never bypasses a same-cycle push: if the FIFO is empty at the tick, it is an underrun even if a push occurs that cycle.
- A full FIFO in IDLE simply back-pressures.

FSM (gain is 9-bit, 0..256):
- IDLE: gain=0, cur_sample=0.
  - Go to RAMP_UP when enable_in=1 and occupancy ≥ PREFILL.
  - The transition is evaluated every cycle, not only on ticks.
- RAMP_UP: on each tick, gain += 1.
  - Go to PLAY when gain reaches 256 (on that tick's update).
  - If enable_in=0 in any cycle, go to RAMP_DOWN with gain unchanged.
- PLAY: gain held at 256; go to RAMP_DOWN when enable_in=0.
- RAMP_DOWN: on each tick, gain -= 1.
  - When gain reaches 0, go to IDLE and clear cur_sample.
  - enable_in=1 during RAMP_DOWN returns to RAMP_UP from the current gain.
  - FIFO contents are retained on return to IDLE.

Sample update (every tick in RAMP_UP, PLAY and RAMP_DOWN):
- If the FIFO is non-empty, pop into cur_sample.
- If it is empty, keep cur_sample, pulse underrun_out, and increment underrun_count_out, saturating at 255.

Output arithmetic and latency:
- level_out is registered: level_out <= (cur_sample × gain) >>> 8.
  - Signed 16×9 product into a 25-bit intermediate, arithmetic shift, floor rounding.
  - The result always fits 16 bits; gain=256 reproduces the sample exactly.
- With the tick in cycle T, cur_sample and gain update at the end of T, and level_out reflects them from cycle T+2.
- level_out is otherwise constant between ticks.

Test Plan:
Bench parameters: SAMPLE_PERIOD=4, FIFO_DEPTH=4, PREFILL=2.
1. Reset, then observe 12 cycles -> level_out=0, sample_ready_out=1, sample_tick_out high in cycles 3, 7, 11; underrun_count_out=0, playing_out=0.
2. Push 4 samples of 1000 with enable_in=0, then a 5th -> sample_ready_out=0 after the 4th push; 5th not accepted; level_out stays 0; state IDLE.
3. Keep the FIFO topped with 16384 and raise enable_in -> gain 1,2,… per tick; first nonzero level_out = 64 (16384×1>>>8); reaches 16384 after 256 ticks; playing_out=1 throughout.
4. In PLAY at sample -1000, drop enable_in -> level_out decreases per tick; gain=255 gives -997 (floor); reaches 0; IDLE after 256 ticks; playing_out=0.
5. In PLAY with sample 500, stop pushing -> after the FIFO drains, each tick pulses underrun_out, level_out holds 500, and the counter increments; after 300 underruns the counter reads 255.
6. Assert rst_in mid RAMP_UP (gain=100) -> the next cycle shows level_out=0, FIFO empty, IDLE, counter cleared; re-enable with PREFILL samples restarts the ramp from gain 0.
